// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one RAM port between the instruction-fetch requester (i-side) and the
// load/store requester (d-side). Each access is sequenced by a registered FSM
// (IDLE -> DACC/IACC -> IDLE). RAM strobes are held until ram_ready. The granted
// requester sees its wait output drop in the same cycle as ram_ready.
//
// The data side has priority. A burst counter limits how many data grants in a
// row can pass a pending instruction fetch. A watchdog abandons any access that
// the RAM leaves unanswered for TIMEOUT cycles, and sets a sticky error flag.
//
// Ports
//   CLK, nRST            clock (rising edge), asynchronous active-low reset
//   iREN, iaddr          instruction read request / word address
//   iload, iwait         instruction data (valid on completion) / wait
//   dREN, dWEN           data read / write request (write wins when both set)
//   daddr, dstore        data address / write data
//   dload, dwait         data read result (valid on completion) / wait
//   ram_REN, ram_WEN     RAM read / write strobes
//   ram_addr, ram_store  RAM address / write data
//   ram_load, ram_ready  RAM read data / access complete this cycle
//   busy                 FSM is not IDLE
//   timeout_err          sticky watchdog flag
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int MAX_DBURST = 4,    // 1..15
    parameter int TIMEOUT    = 255   // 1..255
) (
    input  logic        CLK,
    input  logic        nRST,
    // instruction side
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic [31:0] iload,
    output logic        iwait,
    // data side
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic [31:0] dload,
    output logic        dwait,
    // RAM port
    output logic        ram_REN,
    output logic        ram_WEN,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_store,
    input  logic [31:0] ram_load,
    input  logic        ram_ready,
    // status
    output logic        busy,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DACC = 2'd1,
        IACC = 2'd2
    } state_t;

    localparam logic [3:0] BURST_MAX = 4'(MAX_DBURST);
    // The watchdog fires when a cycle without ready would bring the count to
    // TIMEOUT. In that case the count still shows TIMEOUT-1 during that cycle.
    localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 1);

    state_t     state_reg, state_next;
    logic [3:0] burst_reg, burst_next;
    logic [7:0] wdog_reg,  wdog_next;
    logic       err_reg,   err_next;

    logic d_req;
    logic d_done;
    logic i_done;

    assign d_req  = dREN | dWEN;

    // A completion needs the granted request to still be present. A request
    // withdrawn in the same cycle as ram_ready counts as an abort.
    assign d_done = (state_reg == DACC) & ram_ready & d_req;
    assign i_done = (state_reg == IACC) & ram_ready & iREN;

    // -------------------------------------------------------------------------
    // State and counters
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_reg <= IDLE;
            burst_reg <= '0;
            wdog_reg  <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            burst_reg <= burst_next;
            wdog_reg  <= wdog_next;
            err_reg   <= err_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next state, counters and RAM strobes
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        burst_next = burst_reg;
        wdog_next  = wdog_reg;
        err_next   = err_reg;
        ram_REN    = 1'b0;
        ram_WEN    = 1'b0;
        ram_addr   = '0;
        ram_store  = '0;

        case (state_reg)
            IDLE: begin
                // Clearing here means every access starts with a zero count.
                wdog_next = '0;
                if (d_req) begin
                    // After a full burst of data grants, a pending fetch wins.
                    if ((burst_reg == BURST_MAX) && iREN)
                        state_next = IACC;
                    else
                        state_next = DACC;
                end else if (iREN) begin
                    state_next = IACC;
                end
            end

            DACC: begin
                ram_addr  = daddr;
                ram_store = dstore;
                if (dWEN)
                    ram_WEN = 1'b1;
                else
                    ram_REN = 1'b1;

                if (!d_req) begin
                    state_next = IDLE;
                    wdog_next  = '0;
                end else if (ram_ready) begin
                    state_next = IDLE;
                    wdog_next  = '0;
                    // Count data grants only while a fetch is waiting.
                    // Otherwise the burst counter restarts.
                    if (!iREN)
                        burst_next = '0;
                    else if (burst_reg != BURST_MAX)
                        burst_next = burst_reg + 4'd1;
                end else if (wdog_reg == WDOG_LAST) begin
                    state_next = IDLE;
                    wdog_next  = '0;
                    err_next   = 1'b1;
                end else begin
                    wdog_next = wdog_reg + 8'd1;
                end
            end

            IACC: begin
                ram_REN  = 1'b1;
                ram_addr = iaddr;

                if (!iREN) begin
                    state_next = IDLE;
                    wdog_next  = '0;
                end else if (ram_ready) begin
                    state_next = IDLE;
                    wdog_next  = '0;
                    burst_next = '0;
                end else if (wdog_reg == WDOG_LAST) begin
                    state_next = IDLE;
                    wdog_next  = '0;
                    err_next   = 1'b1;
                end else begin
                    wdog_next = wdog_reg + 8'd1;
                end
            end

            default: begin
                state_next = IDLE;
                wdog_next  = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Requester-facing outputs
    // -------------------------------------------------------------------------
    assign dwait       = d_req & ~((state_reg == DACC) & ram_ready);
    assign iwait       = iREN  & ~((state_reg == IACC) & ram_ready);
    assign dload       = d_done ? ram_load : '0;
    assign iload       = i_done ? ram_load : '0;
    assign busy        = (state_reg != IDLE);
    assign timeout_err = err_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Directed scenarios come first: reset, a single read, a write, an abort,
// contention, a ready on the timeout cycle, the watchdog, and an async reset.
// A randomized phase follows. In it the bench acts as both requesters and the
// RAM. A transaction-level model predicts grants, completions, aging and the
// sticky error flag. Inputs change just after the falling edge, and outputs are
// sampled 1 ns later.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int MAXB = 4;
    localparam int TO   = 8;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN;
    logic [31:0] iaddr;
    logic [31:0] iload;
    logic        iwait;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic [31:0] dload;
    logic        dwait;
    logic        ram_REN;
    logic        ram_WEN;
    logic [31:0] ram_addr;
    logic [31:0] ram_store;
    logic [31:0] ram_load;
    logic        ram_ready;
    logic        busy;
    logic        timeout_err;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state for the random phase.
    int owner;          // 0 none, 1 data side, 2 instruction side
    int age;            // cycles spent in the current access without ready
    int streak;         // data grants in a row that a waiting fetch has seen
    logic err_m;
    bit d_pend, i_pend, d_fin, i_fin, still_req;
    int ilow;

    always #5 CLK = ~CLK;

    mem_arbiter #(.MAX_DBURST(MAXB), .TIMEOUT(TO)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dload(dload), .dwait(dwait),
        .ram_REN(ram_REN), .ram_WEN(ram_WEN), .ram_addr(ram_addr),
        .ram_store(ram_store), .ram_load(ram_load), .ram_ready(ram_ready),
        .busy(busy), .timeout_err(timeout_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        nRST = 1'b0; iREN = 1'b0; iaddr = '0; dREN = 1'b0; dWEN = 1'b0;
        daddr = '0; dstore = '0; ram_load = '0; ram_ready = 1'b0;
        d_pend = 1'b0; i_pend = 1'b0;

        // ---- reset state ----
        @(negedge CLK); #1;
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_ren", ram_REN, 1'b0);
        chk1("rst_wen", ram_WEN, 1'b0);
        chk("rst_addr", ram_addr, 32'h0);
        chk("rst_store", ram_store, 32'h0);
        chk1("rst_terr", timeout_err, 1'b0);
        chk1("rst_dwait", dwait, 1'b0);
        chk1("rst_iwait", iwait, 1'b0);
        @(negedge CLK); nRST = 1'b1;

        // ---- single read, ready in the 3rd DACC cycle ----
        @(negedge CLK); dREN = 1'b1; daddr = 32'h40; #1;
        chk1("rd_idle_busy", busy, 1'b0);
        chk1("rd_idle_ren", ram_REN, 1'b0);
        chk1("rd_idle_dwait", dwait, 1'b1);
        @(negedge CLK); #1;
        chk1("rd_c1_ren", ram_REN, 1'b1);
        chk1("rd_c1_wen", ram_WEN, 1'b0);
        chk("rd_c1_addr", ram_addr, 32'h40);
        chk1("rd_c1_dwait", dwait, 1'b1);
        chk("rd_c1_dload", dload, 32'h0);
        @(negedge CLK); #1;
        chk1("rd_c2_ren", ram_REN, 1'b1);
        chk1("rd_c2_dwait", dwait, 1'b1);
        @(negedge CLK); ram_ready = 1'b1; ram_load = 32'hDEADBEEF; #1;
        chk1("rd_c3_ren", ram_REN, 1'b1);
        chk1("rd_c3_dwait", dwait, 1'b0);
        chk("rd_c3_dload", dload, 32'hDEADBEEF);
        @(negedge CLK); dREN = 1'b0; ram_ready = 1'b0; ram_load = '0; #1;
        chk1("rd_c4_busy", busy, 1'b0);
        chk1("rd_c4_ren", ram_REN, 1'b0);

        // ---- write with dREN and dWEN both set ----
        @(negedge CLK); dREN = 1'b1; dWEN = 1'b1; daddr = 32'h80; dstore = 32'h12345678; #1;
        chk1("wr_idle_dwait", dwait, 1'b1);
        @(negedge CLK); #1;
        chk1("wr_wen", ram_WEN, 1'b1);
        chk1("wr_ren", ram_REN, 1'b0);
        chk("wr_addr", ram_addr, 32'h80);
        chk("wr_store", ram_store, 32'h12345678);
        chk1("wr_dwait_hold", dwait, 1'b1);
        @(negedge CLK); ram_ready = 1'b1; #1;
        chk1("wr_dwait_done", dwait, 1'b0);
        chk1("wr_wen_done", ram_WEN, 1'b1);
        @(negedge CLK); dREN = 1'b0; dWEN = 1'b0; ram_ready = 1'b0; #1;
        chk1("wr_after_busy", busy, 1'b0);
        chk1("wr_after_wen", ram_WEN, 1'b0);
        chk("wr_after_store", ram_store, 32'h0);

        // ---- read withdrawn in the 2nd DACC cycle ----
        @(negedge CLK); dREN = 1'b1; daddr = 32'h44; #1;
        @(negedge CLK); #1;
        chk1("ab_c1_busy", busy, 1'b1);
        @(negedge CLK); dREN = 1'b0; #1;
        chk1("ab_c2_busy", busy, 1'b1);
        chk1("ab_c2_ren", ram_REN, 1'b1);
        chk("ab_c2_dload", dload, 32'h0);
        @(negedge CLK); #1;
        chk1("ab_c3_busy", busy, 1'b0);
        chk1("ab_c3_ren", ram_REN, 1'b0);

        // ---- contention: D,D,D,D,I repeating, ready every access ----
        ilow = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge CLK);
            if (k == 0) begin
                iREN = 1'b1; dREN = 1'b1; iaddr = 32'h100; daddr = 32'h200;
                ram_ready = 1'b1; ram_load = 32'hA5A50000;
            end
            #1;
            if (iwait == 1'b0) ilow++;
            if ((k % 2) == 0) begin
                chk1("ct_idle_busy", busy, 1'b0);
                chk1("ct_idle_iwait", iwait, 1'b1);
                chk1("ct_idle_dwait", dwait, 1'b1);
            end else if (((k / 2) % 5) == 4) begin
                chk("ct_i_addr", ram_addr, 32'h100);
                chk1("ct_i_iwait", iwait, 1'b0);
                chk1("ct_i_dwait", dwait, 1'b1);
                chk("ct_i_iload", iload, 32'hA5A50000);
            end else begin
                chk("ct_d_addr", ram_addr, 32'h200);
                chk1("ct_d_iwait", iwait, 1'b1);
                chk1("ct_d_dwait", dwait, 1'b0);
            end
        end
        chk("ct_iwait_lows", 32'(ilow), 32'd2);
        @(negedge CLK); iREN = 1'b0; dREN = 1'b0; ram_ready = 1'b0; #1;
        chk1("ct_end_busy", busy, 1'b0);

        // ---- ready in the last cycle before the timeout ----
        @(negedge CLK); iREN = 1'b1; iaddr = 32'h300; #1;
        for (int c = 1; c <= TO; c++) begin
            @(negedge CLK);
            if (c == TO) begin ram_ready = 1'b1; ram_load = 32'hCAFEF00D; end
            #1;
            chk1("te_busy", busy, 1'b1);
            chk("te_addr", ram_addr, 32'h300);
            chk1("te_iwait", iwait, (c == TO) ? 1'b0 : 1'b1);
            chk1("te_terr", timeout_err, 1'b0);
        end
        chk("te_iload", iload, 32'hCAFEF00D);
        @(negedge CLK); iREN = 1'b0; ram_ready = 1'b0; #1;
        chk1("te_after_busy", busy, 1'b0);
        chk1("te_after_terr", timeout_err, 1'b0);

        // ---- watchdog: RAM never ready ----
        @(negedge CLK); iREN = 1'b1; iaddr = 32'h304; #1;
        for (int c = 1; c <= TO; c++) begin
            @(negedge CLK); #1;
            chk1("wd_busy", busy, 1'b1);
            chk1("wd_iwait", iwait, 1'b1);
            chk1("wd_terr_pre", timeout_err, 1'b0);
        end
        @(negedge CLK); #1;
        chk1("wd_idle_busy", busy, 1'b0);
        chk1("wd_terr", timeout_err, 1'b1);
        chk1("wd_idle_iwait", iwait, 1'b1);
        @(negedge CLK); ram_ready = 1'b1; ram_load = 32'h0BADF00D; #1;
        chk1("wd_re_busy", busy, 1'b1);
        chk1("wd_re_iwait", iwait, 1'b0);
        chk("wd_re_iload", iload, 32'h0BADF00D);
        @(negedge CLK); iREN = 1'b0; ram_ready = 1'b0; #1;
        chk1("wd_sticky", timeout_err, 1'b1);
        chk1("wd_end_busy", busy, 1'b0);

        // ---- asynchronous reset in the middle of IACC ----
        @(negedge CLK); iREN = 1'b1; iaddr = 32'h308; #1;
        @(negedge CLK); #1;
        chk1("ar_busy_pre", busy, 1'b1);
        chk1("ar_ren_pre", ram_REN, 1'b1);
        #1 nRST = 1'b0;
        #1;
        chk1("ar_ren", ram_REN, 1'b0);
        chk1("ar_busy", busy, 1'b0);
        chk1("ar_terr", timeout_err, 1'b0);
        chk("ar_addr", ram_addr, 32'h0);
        iREN = 1'b0;
        @(negedge CLK); nRST = 1'b1;

        // ---- randomized phase against the reference model ----
        owner = 0; age = 0; streak = 0; err_m = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge CLK);
            if (!d_pend && ($urandom_range(0, 9) < 4)) begin
                d_pend = 1'b1;
                case ($urandom_range(0, 2))
                    0:       begin dREN = 1'b1; dWEN = 1'b0; end
                    1:       begin dREN = 1'b0; dWEN = 1'b1; end
                    default: begin dREN = 1'b1; dWEN = 1'b1; end
                endcase
                daddr  = $urandom;
                dstore = $urandom;
            end
            if (!d_pend) begin dREN = 1'b0; dWEN = 1'b0; end
            if (!i_pend && ($urandom_range(0, 9) < 4)) begin
                i_pend = 1'b1;
                iaddr  = $urandom;
            end
            iREN = i_pend;
            // Periodic silent windows force watchdog expiries.
            ram_ready = ((cyc % 100) >= 80) ? 1'b0 : ($urandom_range(0, 9) < 6);
            ram_load  = $urandom;
            #1;

            d_fin = (owner == 1) && ram_ready && d_pend;
            i_fin = (owner == 2) && ram_ready && i_pend;
            chk1("rnd_busy", busy, owner != 0);
            chk1("rnd_ren", ram_REN, (owner == 2) || ((owner == 1) && !dWEN));
            chk1("rnd_wen", ram_WEN, (owner == 1) && dWEN);
            chk("rnd_addr", ram_addr, (owner == 1) ? daddr : (owner == 2) ? iaddr : 32'h0);
            chk("rnd_store", ram_store, (owner == 1) ? dstore : 32'h0);
            chk1("rnd_dwait", dwait, d_pend && !((owner == 1) && ram_ready));
            chk1("rnd_iwait", iwait, i_pend && !((owner == 2) && ram_ready));
            chk("rnd_dload", dload, d_fin ? ram_load : 32'h0);
            chk("rnd_iload", iload, i_fin ? ram_load : 32'h0);
            chk1("rnd_terr", timeout_err, err_m);

            // Advance the model across the coming rising edge.
            if (owner == 0) begin
                if (d_pend)
                    owner = ((streak == MAXB) && i_pend) ? 2 : 1;
                else if (i_pend)
                    owner = 2;
                age = 0;
            end else begin
                still_req = (owner == 1) ? d_pend : i_pend;
                if (!still_req) begin
                    owner = 0;
                end else if (ram_ready) begin
                    if (owner == 1)
                        streak = i_pend ? ((streak < MAXB) ? streak + 1 : MAXB) : 0;
                    else
                        streak = 0;
                    owner = 0;
                end else begin
                    age++;
                    if (age == TO) begin
                        err_m = 1'b1;
                        owner = 0;
                    end
                end
            end
            if (d_fin) d_pend = 1'b0;
            if (i_fin) i_pend = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single RAM port between the instruction-fetch requester (i-side) and the load/store requester (d-side) of the single-cycle datapath.
- Sequences each access through a registered state machine and holds the RAM strobes until the RAM reports ready.
- Returns a one-cycle "not waiting" completion to the granted requester.
- Data side has priority; a fairness counter bounds instruction starvation, and a watchdog flags a RAM that never answers.

Parameters:
- MAX_DBURST, 4: consecutive data grants allowed while an i-request is pending before the instruction side is forced to win (1..15).
- TIMEOUT, 255: cycles in an access state before the access is abandoned (8-bit counter; 1..255).

Ports:
- CLK  in  1  system clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- iREN  in  1  instruction read request; held until iwait low.
- iaddr  in  32  instruction word address.
- iload  out  32  instruction data; valid when iREN & ~iwait.
- iwait  out  1  high while an i-request is outstanding.
- dREN  in  1  data read request.
- dWEN  in  1  data write request.
- daddr  in  32  data address.
- dstore  in  32  write data.
- dload  out  32  read data; valid when dREN & ~dwait.
- dwait  out  1  high while a d-request is outstanding.
- ram_REN  out  1  RAM read strobe.
- ram_WEN  out  1  RAM write strobe.
- ram_addr  out  32  RAM address.
- ram_store  out  32  RAM write data.
- ram_load  in  32  RAM read data.
- ram_ready  in  1  RAM access complete this cycle.
- busy  out  1  state != IDLE.
- timeout_err  out  1  sticky watchdog flag.

Behaviour:
- Reset (async, nRST low): state IDLE; burst counter 0; watchdog counter 0; timeout_err 0. ram_REN, ram_WEN, busy drop immediately. ram_addr and ram_store are 0. Reset mid-access abandons the access with no completion.
- States: IDLE, DACC, IACC.
- IDLE: no RAM strobes.
  - d-request present (dREN | dWEN): go to DACC next edge, unless the burst counter == MAX_DBURST and iREN is high, in which case go to IACC.
  - Else iREN: go to IACC.
  - Else stay in IDLE.
  - Decision latency is one cycle: a request seen at edge N has its RAM strobe asserted from cycle N+1.
- DACC:
  - ram_addr=daddr; ram_store=dstore.
  - dWEN high: ram_WEN=1, ram_REN=0. dWEN has priority when dREN and dWEN are both high.
  - Otherwise ram_REN=1.
- IACC: ram_REN=1; ram_addr=iaddr; ram_WEN=0.
- Completion: in DACC/IACC with ram_ready=1, the granted requester's wait is 0 that same cycle (combinational). dload/iload = ram_load pass-through. Next state is IDLE.
  - Back-to-back accesses therefore cost at least 2 cycles each.
- Wait outputs:
  - dwait = (dREN|dWEN) & ~(state==DACC & ram_ready).
  - iwait = iREN & ~(state==IACC & ram_ready).
  - With no request, wait is 0.
- Loads: dload and iload are 0 when not completing.
- Burst counter:
  - Increments on each DACC completion while iREN is high, saturating at MAX_DBURST.
  - Clears on any IACC completion, and whenever iREN is low at a DACC completion.
- Request withdrawn mid-access (granted requester's request signal low in DACC/IACC): return to IDLE next edge, strobes drop next edge, no completion, and the watchdog counter clears. A changed address mid-access is a requester protocol error; behaviour is unspecified.
- Watchdog counter:
  - Clears on entry to DACC/IACC and increments each cycle in DACC/IACC without ram_ready.
  - On reaching TIMEOUT: timeout_err<=1 (sticky until reset), state<=IDLE, counter cleared.
  - The request stays pending and is re-arbitrated; ram_ready in that same cycle still completes normally and takes priority over the timeout.
- busy = (state != IDLE).

Test Plan:
- Single read: dREN=1, daddr=0x40; RAM answers ram_ready on the 3rd cycle of DACC with ram_load=0xDEADBEEF -> ram_REN high cycles 1-3; dwait=0 and dload=0xDEADBEEF in cycle 3; IDLE in cycle 4.
- Contention: iREN and dREN both held; each access ready after 1 cycle; MAX_DBURST=4 -> grant order D,D,D,D,I,D,...; iwait low exactly once per 10 cycles.
- Write priority: dREN=dWEN=1, daddr=0x80, dstore=0x12345678 -> ram_WEN=1, ram_REN=0, ram_store=0x12345678; dwait low on ram_ready.
- Watchdog: TIMEOUT=8; iREN held; ram_ready never asserted -> after 8 cycles in IACC, timeout_err=1, one IDLE cycle, IACC re-entered; the flag stays 1 after a later successful completion.
- Abort/reset: drop dREN in the 2nd DACC cycle -> IDLE next edge, no dwait low pulse. Separately, pull nRST low mid-IACC -> ram_REN=0 and busy=0 immediately, with no clock edge required.
- Ready on timeout edge: TIMEOUT=8 with ram_ready asserted in the 8th IACC cycle -> normal completion, iwait=0, timeout_err stays 0.
